scope_capture: RTL
==================

Name: scope_capture

Overview:
- Sampling and trigger stage placed directly downstream of the scope clock divider.
- Treats the divider's square-wave output as a sample-rate tick and captures ADC words on each tick into an internal circular buffer.
- Applies level/slope triggering with a fixed pre-trigger depth.
- Exposes a registered read port so the display/readout logic can fetch the finished record.

Parameters:
DW, 8, ADC sample width in bits.
AW, 10, buffer address width; depth = 2^AW samples.
PRE, 256, pre-trigger samples kept before the trigger; legal range 0..2^AW-1.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
tick_in  in  1  divided sample clock from the divider, asynchronous to clk.
adc_data  in  DW  ADC sample, valid whenever a sample strobe occurs.
arm  in  1  one-clk pulse that starts a capture.
trig_level  in  DW  trigger threshold, unsigned.
trig_slope  in  1  1 = rising crossing, 0 = falling crossing.
rd_addr  in  AW  readout address.
rd_data  out  DW  buffer word at rd_addr, registered.
busy  out  1  capture in progress (states PRE, ARMED, POST).
done  out  1  record complete (state DONE).
trig_addr  out  AW  buffer address of the trigger sample.

Behaviour:
- Reset: async on rst; state IDLE; busy=0, done=0, trig_addr=0, rd_data=0, wr_ptr=0, counters=0, prev_valid=0. Buffer contents are not cleared.
- Sync and strobe:
  - tick_in passes through a 2-flop synchroniser plus one history flop.
  - stb = sync2 & ~hist, high exactly one clk per tick_in rising edge.
  - stb asserts 2-3 clk after tick_in rises.
- Writes: on stb in PRE/ARMED/POST, mem[wr_ptr] <= adc_data, then wr_ptr <= wr_ptr+1 (wraps mod 2^AW); prev <= adc_data; prev_valid <= 1.
- Trigger condition, evaluated only on stb in ARMED and only when prev_valid=1:
  - rising: prev < trig_level && adc_data >= trig_level.
  - falling: prev > trig_level && adc_data <= trig_level.
- FSM:
  - IDLE: arm -> PRE, or ARMED if PRE==0. Clears cnt and prev_valid; wr_ptr is kept.
  - PRE: each stb increments cnt; the stb bringing cnt to PRE -> ARMED.
  - ARMED: stb with trigger -> POST, trig_addr <= current wr_ptr; the trigger sample counts as post sample 1 (cnt <= 1). Waits indefinitely for a trigger.
  - POST: each stb increments cnt; when cnt reaches 2^AW-PRE after the write -> DONE.
  - DONE: done=1; arm -> restart exactly as from IDLE; done drops the cycle after arm.
- arm while busy is ignored. arm coincident with stb in IDLE/DONE: the transition is taken and that stb is not written.
- Record layout: oldest sample at trig_addr-PRE (mod 2^AW). Record spans exactly 2^AW consecutive samples.
- Readout: rd_data <= mem[rd_addr] every clk, 1-clk latency, legal in any state. During capture it returns whatever is currently stored; there is no read/write collision hazard beyond that.
- Trigger arithmetic: unsigned compare, DW bits, no hysteresis.
- Reset mid-capture: immediate abort to IDLE; partially written data stays in memory.

Optional Feature:
- Macro SCOPE_CAPTURE_FORCE_TRIG_EN.
- Defined:
  - Adds input force_trig (1 bit).
  - A force_trig pulse in ARMED sets a sticky flag; the next stb in ARMED is treated as the trigger regardless of level/slope or prev_valid.
  - The flag clears on leaving ARMED and on rst.
- Undefined: port absent; only the level/slope trigger exists.

Test Plan:
- Reset: rst=1 mid-run -> busy=0, done=0, trig_addr=0, rd_data=0 at next clk; no writes while rst=1.
- Basic capture:
  - Setup: AW=4, PRE=4, DW=8, tick_in period 20 clk; adc_data ramps 0,1,2,... per stb; trig_level=100, trig_slope=1; arm before sample 0.
  - Response: trigger on sample 100; trig_addr=4; done after 12 post samples (value 111).
  - Readback: rd_addr=0 -> 96; rd_addr=4 -> 100; rd_addr=15 -> 111, each 1 clk after address.
- Falling slope never crossed: adc_data constant 50, trig_level=100, trig_slope=0 -> state stays ARMED, busy=1, done=0 for 1000 ticks; extra arm pulses ignored.
- Strobe timing: one tick_in rising edge -> exactly one stb-driven write, occurring 2-3 clk later; tick_in held high -> no further writes.
- Rearm from DONE: arm in DONE -> done=0 next clk, busy=1, new record; PRE=0 variant enters ARMED directly and requires one sample for prev_valid before triggering.
- FORCE (macro defined): adc_data constant 7, force_trig pulse in ARMED -> next stb becomes trigger, trig_addr = that write address; done after 2^AW-PRE samples.

Source files
------------

// File: rtl/scope_capture.sv
`default_nettype none
// ============================================================================
// Module   : scope_capture
// Brief    : Tick-synchronised ADC capture into a circular buffer with
//            level/slope trigger, fixed pre-trigger depth and a registered
//            read port. Optional macro SCOPE_CAPTURE_FORCE_TRIG_EN adds a
//            force_trig input.
// Revision : 1.0 - initial release
// ============================================================================
module scope_capture #(
    parameter int DW  = 8,
    parameter int AW  = 10,
    parameter int PRE = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_in,
    input  logic [DW-1:0] adc_data,
    input  logic          arm,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_slope,
`ifdef SCOPE_CAPTURE_FORCE_TRIG_EN
    input  logic          force_trig,
`endif
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] trig_addr
);

    // Counter is one bit wider than the address so it can hold 2^AW.
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] c_PRE_CNT  = CW'(PRE);
    localparam logic [CW-1:0] c_POST_CNT = CW'((1 << AW) - PRE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_hist;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [DW-1:0] r_prev;
    logic          r_prev_valid;
    logic          w_prev_valid_nxt;
    logic [AW-1:0] r_trig_addr;
    logic [AW-1:0] w_trig_addr_nxt;
    logic [DW-1:0] r_rd_data;
    logic          w_stb;
    logic          w_wr;
    logic          w_rise;
    logic          w_fall;
    logic          w_lvl_trig;
    logic          w_trig;

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    assign w_stb     = r_sync2 & ~r_hist;
    assign w_cnt_inc = r_cnt + CW'(1);

    assign w_rise     = (r_prev < trig_level) && (adc_data >= trig_level);
    assign w_fall     = (r_prev > trig_level) && (adc_data <= trig_level);
    assign w_lvl_trig = r_prev_valid && (trig_slope ? w_rise : w_fall);

`ifdef SCOPE_CAPTURE_FORCE_TRIG_EN
    logic r_force;

    assign w_trig = w_lvl_trig || r_force;

    // Sticky only while the FSM remains in ARMED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_force <= 1'b0;
        end else if ((r_state == S_ARMED) && (w_state_nxt == S_ARMED)) begin
            r_force <= r_force | force_trig;
        end else begin
            r_force <= 1'b0;
        end
    end
`else
    assign w_trig = w_lvl_trig;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_prev_valid_nxt = r_prev_valid;
        w_trig_addr_nxt  = r_trig_addr;
        w_wr             = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                // A strobe coincident with arm is deliberately not written.
                if (arm) begin
                    w_state_nxt      = (PRE == 0) ? S_ARMED : S_PRE;
                    w_cnt_nxt        = '0;
                    w_prev_valid_nxt = 1'b0;
                end
            end
            S_PRE: begin
                if (w_stb) begin
                    w_wr             = 1'b1;
                    w_prev_valid_nxt = 1'b1;
                    w_cnt_nxt        = w_cnt_inc;
                    if (w_cnt_inc == c_PRE_CNT) begin
                        w_state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (w_stb) begin
                    w_wr             = 1'b1;
                    w_prev_valid_nxt = 1'b1;
                    if (w_trig) begin
                        w_trig_addr_nxt = r_wr_ptr;
                        w_cnt_nxt       = CW'(1);
                        w_state_nxt     = (c_POST_CNT == CW'(1)) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (w_stb) begin
                    w_wr             = 1'b1;
                    w_prev_valid_nxt = 1'b1;
                    w_cnt_nxt        = w_cnt_inc;
                    if (w_cnt_inc == c_POST_CNT) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_hist       <= 1'b0;
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_trig_addr  <= '0;
            r_rd_data    <= '0;
        end else begin
            r_sync1      <= tick_in;
            r_sync2      <= r_sync1;
            r_hist       <= r_sync2;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev_valid <= w_prev_valid_nxt;
            r_trig_addr  <= w_trig_addr_nxt;
            r_rd_data    <= r_mem[rd_addr];
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_prev   <= adc_data;
            end
        end
    end

    // Buffer storage is never reset; contents survive an abort.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= adc_data;
        end
    end

    assign busy      = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    assign done      = (r_state == S_DONE);
    assign trig_addr = r_trig_addr;
    assign rd_data   = r_rd_data;

endmodule
`default_nettype wire
